inst_rom_resp: RTL

Synthesizable instruction-memory responder. It is the memory end of the CPU fetch interface (rom_ce / inst_addr / inst). It replaces the zero-latency combinational ROM model with a word-addressed synchronous memory that has a configurable wait-state count. A stall request back to the CPU and a word-wide load port let the bench fill program images through a port instead of hierarchical writes.

---
 rtl/inst_rom_resp.sv | 79 +++++++
 1 files changed

// File: rtl/inst_rom_resp.sv
// inst_rom_resp: word-addressed synchronous instruction memory with programmable wait states,
// CPU stall request, a word-wide load port and a sticky out-of-range fetch flag.
module inst_rom_resp #(
  parameter int          DEPTH_LOG2  = 10,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] RESET_INST  = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rom_ce,
  input  logic [31:0]           inst_addr,
  output logic [31:0]           inst,
  output logic                  inst_valid,
  output logic                  stallreq,
  input  logic                  load_we,
  input  logic [DEPTH_LOG2-1:0] load_addr,
  input  logic [31:0]           load_data,
  output logic                  oob_err
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("inst_rom_resp: WAIT_CYCLES must be in 0..15");
  end
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [29:0] areg_q, areg_d, rd_addr;
  logic [31:0] data_q, data_d;
  logic        oob_q, oob_d, enter_resp, in_range;
  logic [31:0] mem [2**DEPTH_LOG2];
  logic        unused;
  assign unused = ^inst_addr[1:0];
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    areg_d     = areg_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: if (rom_ce) begin
        areg_d     = inst_addr[31:2];
        cnt_d      = CNT_INIT;
        state_d    = WAIT_CYCLES == 0 ? RESP : WAIT;
        enter_resp = WAIT_CYCLES == 0;
      end
      WAIT: if (cnt_q == 4'd0) begin
        state_d    = RESP;
        enter_resp = 1'b1;
      end else cnt_d = cnt_q - 4'd1;
      default: state_d = IDLE;
    endcase
  end
  // A zero-wait fetch enters RESP on its capture edge, before areg holds the address.
  assign rd_addr  = state_q == IDLE ? inst_addr[31:2] : areg_q;
  assign in_range = rd_addr[29:DEPTH_LOG2] == '0;
  assign data_d   = enter_resp ? (in_range ? mem[rd_addr[DEPTH_LOG2-1:0]] : 32'h0) : data_q;
  assign oob_d    = oob_q | (enter_resp & ~in_range);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      areg_q  <= '0;
      data_q  <= RESET_INST;
      oob_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      areg_q  <= areg_d;
      data_q  <= data_d;
      oob_q   <= oob_d;
    end
  end
  // Not reset; the read above samples the pre-write contents on a colliding edge.
  always_ff @(posedge clk)
    if (load_we) mem[load_addr] <= load_data;
  assign inst_valid = state_q == RESP;
  assign inst       = inst_valid ? data_q : 32'h0;
  assign stallreq   = rom_ce && !(inst_valid && areg_q == inst_addr[31:2]);
  assign oob_err    = oob_q;
endmodule
